// File: rtl/min_pulse_shaper_if.sv
// Request/status bundle between control logic and the pulse shaper.
// The shaper takes the slave side; the driving logic (or a bench) takes master.
interface min_pulse_shaper_if;
   logic clk_en;
   logic in;
   logic inhibit;
   logic out;
   logic busy;

   modport master (output clk_en, in, inhibit, input out, busy);
   modport slave  (input clk_en, in, inhibit, output out, busy);
endinterface

// File: rtl/min_pulse_shaper.sv
// Output conditioner: enforces minimum asserted/deasserted phase lengths on a pin
// and forces the pin to its default level while a fault inhibit is present.
module min_pulse_shaper #(
   parameter int MIN_ACTIVE     = 4,
   parameter int MIN_IDLE       = 8,
   parameter bit DEFAULT_OUTPUT = 1'b0,
   parameter int COUNTER_WIDTH  = $clog2(((MIN_ACTIVE > MIN_IDLE) ? MIN_ACTIVE : MIN_IDLE) + 1)
) (
   input  logic               clk,
   input  logic               reset,
   min_pulse_shaper_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACT_HOLD, ACTIVE, IDLE_HOLD} state_t;

   localparam logic [COUNTER_WIDTH-1:0] ACT_LAST  = COUNTER_WIDTH'(MIN_ACTIVE - 1);
   localparam logic [COUNTER_WIDTH-1:0] IDLE_LAST = COUNTER_WIDTH'(MIN_IDLE - 1);

   state_t                   r_state;
   logic [COUNTER_WIDTH-1:0] r_cnt;
   logic                     r_out;
   logic                     r_busy;

   state_t                   w_state_nxt;
   logic [COUNTER_WIDTH-1:0] w_cnt_nxt;
   logic                     w_req;
   logic                     w_asserted_nxt;

   assign w_req = (bus.in != DEFAULT_OUTPUT);

   // Counter only advances until it reaches the phase's last value, so equality is the expiry test.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (!bus.inhibit && w_req) begin
               w_state_nxt = ACT_HOLD;
               w_cnt_nxt   = '0;
            end
         end
         ACT_HOLD: begin
            if (bus.inhibit) begin
               w_state_nxt = IDLE_HOLD;
               w_cnt_nxt   = '0;
            end else if (r_cnt == ACT_LAST) begin
               if (!w_req) begin
                  w_state_nxt = IDLE_HOLD;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = ACTIVE;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ACTIVE: begin
            if (bus.inhibit || !w_req) begin
               w_state_nxt = IDLE_HOLD;
               w_cnt_nxt   = '0;
            end
         end
         IDLE_HOLD: begin
            if (r_cnt == IDLE_LAST) begin
               if (w_req && !bus.inhibit) begin
                  w_state_nxt = ACT_HOLD;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign w_asserted_nxt = (w_state_nxt == ACT_HOLD) || (w_state_nxt == ACTIVE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_out   <= DEFAULT_OUTPUT;
         r_busy  <= 1'b0;
      end else if (bus.clk_en) begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_out   <= w_asserted_nxt ? ~DEFAULT_OUTPUT : DEFAULT_OUTPUT;
         r_busy  <= (w_state_nxt == ACT_HOLD) || (w_state_nxt == IDLE_HOLD);
      end
   end

   assign bus.out  = r_out;
   assign bus.busy = r_busy;

endmodule

// File: tb/tb_min_pulse_shaper.sv
// Bench for min_pulse_shaper: directed scenarios plus randomized traffic on three
// configurations, checked against a phase-length reference model.
module tb_min_pulse_shaper;

   localparam int SAT = 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b1;
   logic req = 1'b0;
   logic inh = 1'b0;

   int n_pass  = 0;
   int n_total = 0;

   // Reference: per configuration, whether the pin is asserted and how many
   // enabled edges the current phase has lasted (saturating).
   bit m_act [3];
   int m_len [3];

   always #5 clk = ~clk;

   min_pulse_shaper_if if0 ();
   min_pulse_shaper_if if1 ();
   min_pulse_shaper_if if2 ();

   assign if0.clk_en = en;  assign if0.in = req;   assign if0.inhibit = inh;
   assign if1.clk_en = en;  assign if1.in = ~req;  assign if1.inhibit = inh;
   assign if2.clk_en = en;  assign if2.in = req;   assign if2.inhibit = inh;

   min_pulse_shaper u_dut0 (.clk(clk), .reset(rst), .bus(if0.slave));
   min_pulse_shaper #(.DEFAULT_OUTPUT(1'b1)) u_dut1 (.clk(clk), .reset(rst), .bus(if1.slave));
   min_pulse_shaper #(.MIN_ACTIVE(1), .MIN_IDLE(1)) u_dut2 (.clk(clk), .reset(rst), .bus(if2.slave));

   function automatic int ma(int k);  return (k == 2) ? 1 : 4;  endfunction
   function automatic int mi(int k);  return (k == 2) ? 1 : 8;  endfunction
   function automatic bit dflt(int k); return (k == 1);        endfunction

   function automatic logic get_out(int k);
      return (k == 0) ? if0.out : (k == 1) ? if1.out : if2.out;
   endfunction
   function automatic logic get_busy(int k);
      return (k == 0) ? if0.busy : (k == 1) ? if1.busy : if2.busy;
   endfunction

   function automatic logic exp_out(int k);
      return m_act[k] ^ dflt(k);
   endfunction
   function automatic logic exp_busy(int k);
      return m_act[k] ? (m_len[k] <= ma(k)) : (m_len[k] <= mi(k));
   endfunction

   task automatic model_step(int k);
      if (rst) begin
         m_act[k] = 1'b0;
         m_len[k] = SAT;
      end else if (en) begin
         if (m_act[k] && (inh || (m_len[k] >= ma(k) && !req))) begin
            m_act[k] = 1'b0;
            m_len[k] = 1;
         end else if (!m_act[k] && req && !inh && m_len[k] >= mi(k)) begin
            m_act[k] = 1'b1;
            m_len[k] = 1;
         end else if (m_len[k] < SAT) begin
            m_len[k] = m_len[k] + 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b1; req = 1'b0; inh = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; req = 1'b1; inh = 1'b0;
      tick(); tick();
      n_total++; if (if0.out !== 1'b0)  $display("FAIL reset_out0 got %b want 0", if0.out);   else n_pass++;
      n_total++; if (if0.busy !== 1'b0) $display("FAIL reset_busy0 got %b want 0", if0.busy); else n_pass++;
      n_total++; if (if1.out !== 1'b1)  $display("FAIL reset_out1 got %b want 1", if1.out);   else n_pass++;
      n_total++; if (if2.out !== 1'b0)  $display("FAIL reset_out2 got %b want 0", if2.out);   else n_pass++;
      rst = 1'b0; req = 1'b0;
   endtask

   task automatic test_single_pulse();
      logic [19:0] so, sb, so1, so2, sb2;
      do_reset();
      req = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         so[i] = if0.out; sb[i] = if0.busy; so1[i] = if1.out;
         so2[i] = if2.out; sb2[i] = if2.busy;
         req = 1'b0;
      end
      n_total++; if (so  !== 20'h0000F) $display("FAIL pulse_out got %h want 0000f", so);   else n_pass++;
      n_total++; if (sb  !== 20'h00FFF) $display("FAIL pulse_busy got %h want 00fff", sb);  else n_pass++;
      n_total++; if (so1 !== 20'hFFFF0) $display("FAIL pulse_out_inv got %h want ffff0", so1); else n_pass++;
      n_total++; if (so2 !== 20'h00001) $display("FAIL pulse_out_min1 got %h want 00001", so2); else n_pass++;
      n_total++; if (sb2 !== 20'h00003) $display("FAIL pulse_busy_min1 got %h want 00003", sb2); else n_pass++;
   endtask

   task automatic test_long_request();
      logic [31:0] so, sb;
      do_reset();
      for (int i = 0; i < 32; i++) begin
         req = (i < 20);
         tick();
         so[i] = if0.out; sb[i] = if0.busy;
      end
      n_total++; if (so !== 32'h000FFFFF) $display("FAIL long_out got %h want 000fffff", so);  else n_pass++;
      n_total++; if (sb !== 32'h0FF0000F) $display("FAIL long_busy got %h want 0ff0000f", sb); else n_pass++;
   endtask

   task automatic test_reassert();
      logic [15:0] so;
      do_reset();
      req = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      for (int i = 0; i < 16; i++) begin
         req = (i >= 2);
         tick();
         so[i] = if0.out;
      end
      n_total++; if (so !== 16'hFF00) $display("FAIL reassert_out got %h want ff00", so); else n_pass++;
   endtask

   task automatic test_inhibit();
      logic [13:0] so;
      do_reset();
      req = 1'b1;
      for (int i = 0; i < 14; i++) begin
         inh = (i == 2);
         tick();
         so[i] = if0.out;
      end
      inh = 1'b0;
      n_total++; if (so !== 14'h3C03) $display("FAIL inhibit_out got %h want 3c03", so); else n_pass++;
   endtask

   task automatic test_inhibit_gated();
      do_reset();
      req = 1'b1;
      tick();
      en = 1'b0; inh = 1'b1;
      tick(); tick();
      n_total++; if (if0.out !== 1'b1) $display("FAIL inhibit_gated_hold got %b want 1", if0.out); else n_pass++;
      en = 1'b1;
      tick();
      n_total++; if (if0.out !== 1'b0) $display("FAIL inhibit_gated_fall got %b want 0", if0.out); else n_pass++;
      n_total++; if (if0.busy !== 1'b1) $display("FAIL inhibit_gated_busy got %b want 1", if0.busy); else n_pass++;
      inh = 1'b0; req = 1'b0;
   endtask

   task automatic test_clk_en();
      logic [29:0] so, so1;
      do_reset();
      for (int i = 0; i < 30; i++) begin
         en  = (i % 3 == 0);
         req = (i == 0);
         tick();
         so[i] = if0.out; so1[i] = if1.out;
      end
      en = 1'b1;
      n_total++; if (so  !== 30'h00000FFF) $display("FAIL clken_out got %h want 00000fff", so);      else n_pass++;
      n_total++; if (so1 !== 30'h3FFFF000) $display("FAIL clken_out_inv got %h want 3ffff000", so1); else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 1'b1;
      tick(); tick();
      rst = 1'b1;
      tick();
      n_total++; if (if0.out !== 1'b0)  $display("FAIL midreset_out got %b want 0", if0.out);   else n_pass++;
      n_total++; if (if0.busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", if0.busy); else n_pass++;
      n_total++; if (if1.out !== 1'b1)  $display("FAIL midreset_out_inv got %b want 1", if1.out); else n_pass++;
      rst = 1'b0;
      tick();
      n_total++; if (if0.out !== 1'b1)  $display("FAIL postreset_out got %b want 1", if0.out);  else n_pass++;
      n_total++; if (if0.busy !== 1'b1) $display("FAIL postreset_busy got %b want 1", if0.busy); else n_pass++;
      req = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         en  = ($urandom_range(0, 3) != 0);
         inh = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) req = ~req;
         tick();
         for (int k = 0; k < 3; k++) begin
            n_total++;
            if (get_out(k) !== exp_out(k))
               $display("FAIL rand_out dut%0d cycle %0d got %b want %b", k, c, get_out(k), exp_out(k));
            else n_pass++;
            n_total++;
            if (get_busy(k) !== exp_busy(k))
               $display("FAIL rand_busy dut%0d cycle %0d got %b want %b", k, c, get_busy(k), exp_busy(k));
            else n_pass++;
         end
      end
      rst = 1'b0; en = 1'b1; inh = 1'b0; req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_pulse();
      test_long_request();
      test_reassert();
      test_inhibit();
      test_inhibit_gated();
      test_clk_en();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
